// File: rtl/mem_seq.sv
// Load/store sequencer between the register file and an 8-bit memory port.
// Splits 16-bit accesses into two little-endian byte cycles.
module mem_seq (
  input  logic        clk,
  input  logic        reset_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_wide,
  input  logic [15:0] req_addr,
  input  logic [3:0]  req_reg,
  input  logic [15:0] req_data,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] reg_we,
  output logic [15:0] reg_wdata,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    ACC0,
    ACC1,
    FIN
  } state_e;

  state_e      state_q, state_d;
  logic        write_q;
  logic        wide_q;
  logic [15:0] addr_q;
  logic [3:0]  reg_q;
  logic [15:0] data_q;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] rwd_q, rwd_d;
  logic        accept;

  assign accept = req_valid & (state_q == IDLE);

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      addr_q  <= 16'h0000;
      reg_q   <= 4'h0;
      data_q  <= 16'h0000;
      lo_q    <= 8'h00;
      rwd_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      rwd_q   <= rwd_d;
      if (accept) begin
        write_q <= req_write;
        wide_q  <= req_wide;
        addr_q  <= req_addr;
        reg_q   <= req_reg;
        data_q  <= req_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    lo_d      = lo_q;
    rwd_d     = rwd_q;
    req_ready = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = 8'h00;
    mem_we    = 1'b0;
    reg_we    = 16'h0000;
    reg_wdata = rwd_q;
    done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_d = ACC0;
      end
      ACC0: begin
        mem_we  = write_q;
        if (write_q) mem_wdata = data_q[7:0];
        state_d = wide_q ? ACC1 : FIN;
      end
      ACC1: begin
        // Address wraps naturally at 16 bits
        mem_addr = addr_q + 16'd1;
        mem_we   = write_q;
        if (write_q) mem_wdata = data_q[15:8];
        else lo_d = mem_rdata;
        state_d  = FIN;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
        if (!write_q) begin
          reg_we    = 16'd1 << reg_q;
          reg_wdata = wide_q ? {mem_rdata, lo_q}
                             : {8'h00, mem_rdata};
          rwd_d     = reg_wdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
